// File: rtl/button_debouncer.sv
// Switch debouncer: synchronizes a raw input, then accepts a level change only
// after the synchronized level has been stable for DEBOUNCE_CYCLES+1 samples.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out,
    output logic bouncing
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW       = 2'b00,
        RISE_WAIT = 2'b01,
        HIGH      = 2'b10,
        FALL_WAIT = 2'b11
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A reversal in a WAIT state falls back to the stable state with no credit kept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOW: begin
                cnt_d = '0;
                if (s) state_d = RISE_WAIT;
            end
            RISE_WAIT: begin
                if (!s) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                cnt_d = '0;
                if (!s) state_d = FALL_WAIT;
            end
            FALL_WAIT: begin
                if (s) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign out      = (state_q == HIGH) || (state_q == FALL_WAIT);
    assign bouncing = (state_q == RISE_WAIT) || (state_q == FALL_WAIT);

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus randomized bouncing,
// checked against a run-length model of the debounce rule (DC=4 and DC=1 units).
module tb_button_debouncer;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_s = 1'b0;
    logic out4, bnc4, out1, bnc1;

    int checks = 0;
    int failures = 0;

    int         dc [2] = '{4, 1};
    logic       m_out [2];
    int         m_run [2];
    logic [SYNC-1:0] hist;

    always #5 clk = ~clk;

    button_debouncer #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(SYNC)) u_dc4 (
        .clk(clk), .reset(reset), .in(in_s), .out(out4), .bouncing(bnc4)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(1), .SYNC_STAGES(SYNC)) u_dc1 (
        .clk(clk), .reset(reset), .in(in_s), .out(out1), .bouncing(bnc1)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
        end
    endtask

    task automatic model_clear();
        hist = '0;
        for (int i = 0; i < 2; i++) begin
            m_out[i] = 1'b0;
            m_run[i] = 0;
        end
    endtask

    // The level must differ from the accepted one on DC+1 consecutive samples to flip.
    task automatic model_edge();
        logic s;
        s = hist[SYNC-1];
        for (int i = 0; i < 2; i++) begin
            if (s != m_out[i]) begin
                m_run[i]++;
                if (m_run[i] == dc[i] + 1) begin
                    m_out[i] = s;
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        hist = {hist[SYNC-2:0], in_s};
    endtask

    task automatic step(input logic v);
        in_s = v;
        @(posedge clk);
        model_edge();
        #1;
        check("out_dc4", out4, m_out[0]);
        check("bnc_dc4", bnc4, m_run[0] != 0);
        check("out_dc1", out1, m_out[1]);
        check("bnc_dc1", bnc1, m_run[1] != 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_out4", out4, 1'b0);
        check("rst_bnc4", bnc4, 1'b0);
        check("rst_out1", out1, 1'b0);
        check("rst_bnc1", bnc1, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        model_clear();
        do_reset();

        // clean press: out rises on edge 7, bouncing on edges 3..6
        for (int e = 1; e <= 9; e++) begin
            step(1'b1);
            check("press_out", out4, e >= 7);
            check("press_bnc", bnc4, (e >= 3) && (e < 7));
        end

        // glitch of 3 cycles is rejected
        do_reset();
        repeat (3) step(1'b1);
        repeat (6) step(1'b0);
        check("glitch_out", out4, 1'b0);
        check("glitch_bnc", bnc4, 1'b0);

        // bouncy press: out rises 7 edges after the final rising step
        do_reset();
        step(1'b1); step(1'b0); step(1'b1); step(1'b0);
        for (int e = 1; e <= 8; e++) begin
            step(1'b1);
            check("bouncy_out", out4, e >= 7);
        end

        // release from HIGH, then a blip during FALL_WAIT
        for (int e = 1; e <= 8; e++) begin
            step(1'b0);
            check("release_out", out4, e < 7);
        end
        repeat (8) step(1'b1);
        check("rehigh_out", out4, 1'b1);
        repeat (3) step(1'b0);
        step(1'b1);
        for (int e = 1; e <= 8; e++) begin
            step(1'b0);
            check("blip_out", out4, e < 7);
        end

        // reset mid-qualification (RISE_WAIT, cnt=2), asynchronous clear
        do_reset();
        repeat (5) step(1'b1);
        check("midq_bnc_pre", bnc4, 1'b1);
        do_reset();
        for (int e = 1; e <= 8; e++) begin
            step(1'b1);
            check("midq_out", out4, e >= 7);
        end

        // reset while HIGH drops out asynchronously
        check("high_pre", out4, 1'b1);
        do_reset();
        check("high_post_out", out4, 1'b0);

        // randomized bouncing with occasional resets
        for (int n = 0; n < 400; n++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 10) : $urandom_range(1, 4);
            for (int k = 0; k < len; k++) step(v);
            if ($urandom_range(0, 60) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
